// File: rtl/snail_pkg.sv
// Shared definitions for the Snail bitstream source and the 101 sequence detectors.
//   tx_state_e         : serializer FSM encoding (IDLE=0, SHIFT=1)
//   det_state_e        : detector FSM encoding (SAD/WAIT1/WAIT2)
//   IDLE_LEVEL_DEFAULT : line level driven on D while no word is in flight
//   cnt_width()        : counter width for a modulus n, never below 1 bit
package snail_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        SAD   = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } det_state_e;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snail_tick_div.sv
// Bit-period divider: counts DIV clocks while enabled and flags the terminal count.
//   clk    : system clock
//   _rst   : asynchronous active-low reset
//   en     : count this clock (a bit is being held on the line)
//   start  : restart the count from zero (new word accepted)
//   tick_c : combinational, high on the final clock of the current bit period
module snail_tick_div
    import snail_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic _rst,
    input  logic en,
    input  logic start,
    output logic tick_c
);

    localparam int unsigned     DW   = cnt_width(DIV);
    localparam logic [DW-1:0]   TERM = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // Position inside the current bit period, 0..DIV-1
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            div_cnt <= '0;
        end else if (start) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == TERM) ? '0 : div_cnt + DW'(1);
        end
    end

    assign tick_c = en & (div_cnt == TERM);

endmodule

// File: rtl/snail_bit_serializer.sv
// Parallel-to-serial bit source feeding the 1-bit D input of the Snail 101 detectors.
// Words are accepted on a load/ready handshake and shifted out one bit per DIV
// clocks; a load taken during the final clock of a word continues with no gap.
//   clk     : system clock, all state on rising edge
//   _rst    : asynchronous active-low reset
//   data_in : word to serialize, sampled only at the accepting edge
//   load    : send request, accepted when load & ready at a rising edge
//   ready   : combinational, block can accept a load this cycle
//   D       : registered serial bit to the detector
//   bit_stb : registered one-clock pulse on the first clock of each payload bit
//   busy    : registered, a payload bit is present on D
//   last    : combinational, final clock of the final bit of the current word
module snail_bit_serializer
    import snail_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIV        = 1,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             D,
    output logic             bit_stb,
    output logic             busy,
    output logic             last
);

    localparam int unsigned   BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    tx_state_e        state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [39:0]      txstate;
    logic             tick_c;
    logic             shift_en_c;
    logic             accept_c;

    // Bit that leaves the word next, in the configured order
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit removed; vacated positions fill with zero
    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign shift_en_c = (state == SHIFT);

    snail_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk    (clk),
        ._rst   (_rst),
        .en     (shift_en_c),
        .start  (accept_c),
        .tick_c (tick_c)
    );

    // Handshake decode: depends only on state and counters, never on load
    assign last     = shift_en_c & (bit_cnt == BIT_LAST) & tick_c;
    assign ready    = (state == IDLE) | last;
    assign accept_c = load & ready;

    // FSM, shift register and registered line outputs. The first bit goes
    // straight to D at the accepting edge, so shreg holds only the remainder.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state   <= IDLE;
            txstate <= 40'("IDLE");
            bit_cnt <= '0;
            shreg   <= '0;
            D       <= IDLE_LEVEL;
            bit_stb <= 1'b0;
            busy    <= 1'b0;
        end else begin
            bit_stb <= 1'b0;
            if (accept_c) begin
                state   <= SHIFT;
                txstate <= 40'("SHIFT");
                bit_cnt <= '0;
                shreg   <= drop_bit(data_in);
                D       <= first_bit(data_in);
                bit_stb <= 1'b1;
                busy    <= 1'b1;
            end else if (last) begin
                state   <= IDLE;
                txstate <= 40'("IDLE");
                bit_cnt <= '0;
                shreg   <= '0;
                D       <= IDLE_LEVEL;
                busy    <= 1'b0;
            end else if (tick_c) begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= drop_bit(shreg);
                D       <= first_bit(shreg);
                bit_stb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snail_bit_serializer.sv
// Self-checking bench for snail_bit_serializer. Three instances cover
// DIV=1/MSB first, DIV=3/MSB first and DIV=1/LSB first. Expected line
// behaviour is derived from the word, the bit order and the bit period.
module tb_snail_bit_serializer;

    logic       clk;
    logic       tb_rst;
    int         errors;
    int         checks;

    logic [7:0] m_data, d3_data, l_data;
    logic       m_load, d3_load, l_load;
    logic       m_ready, m_d, m_stb, m_busy, m_last;
    logic       d3_ready, d3_d, d3_stb, d3_busy, d3_last;
    logic       l_ready, l_d, l_stb, l_busy, l_last;

    snail_bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_main (
        .clk(clk), ._rst(tb_rst), .data_in(m_data), .load(m_load), .ready(m_ready),
        .D(m_d), .bit_stb(m_stb), .busy(m_busy), .last(m_last));

    snail_bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_div3 (
        .clk(clk), ._rst(tb_rst), .data_in(d3_data), .load(d3_load), .ready(d3_ready),
        .D(d3_d), .bit_stb(d3_stb), .busy(d3_busy), .last(d3_last));

    snail_bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), ._rst(tb_rst), .data_in(l_data), .load(l_load), .ready(l_ready),
        .D(l_d), .bit_stb(l_stb), .busy(l_busy), .last(l_last));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i (0 = sent first) of a word for a given order
    function automatic logic ref_bit(input logic [7:0] w, input int i, input bit msb);
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic test_reset();
        tb_rst = 1'b0;
        m_load = 0; d3_load = 0; l_load = 0;
        m_data = '0; d3_data = '0; l_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_d, m_busy, m_stb, m_last, m_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_main: got %b expected %b", {m_d, m_busy, m_stb, m_last, m_ready}, 5'b00001);
        end
        checks++;
        if ({d3_d, d3_busy, d3_stb, d3_last, d3_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_div3: got %b expected %b", {d3_d, d3_busy, d3_stb, d3_last, d3_ready}, 5'b00001);
        end
        checks++;
        if ({l_d, l_busy, l_stb, l_last, l_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_lsb: got %b expected %b", {l_d, l_busy, l_stb, l_last, l_ready}, 5'b00001);
        end
        tb_rst = 1'b1;
        @(negedge clk);
    endtask

    // Single word 1010_0000, plus the position of the 101 detection
    task automatic test_basic();
        logic [4:0] obs, exp;
        logic       q[$];
        int         hits, hit_pos;
        m_data = 8'b1010_0000; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0; m_data = 8'h00;
        for (int c = 1; c <= 9; c++) begin
            obs = {m_d, m_busy, m_stb, m_last, m_ready};
            if (c <= 8) exp = {ref_bit(8'b1010_0000, c-1, 1'b1), 1'b1, 1'b1, c == 8, c == 8};
            else        exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic_cycle%0d: got %b expected %b", c, obs, exp);
            end
            if (c <= 8) q.push_back(m_d);
            @(negedge clk);
        end
        hits = 0; hit_pos = -1;
        for (int i = 2; i < q.size(); i++)
            if (q[i-2] == 1'b1 && q[i-1] == 1'b0 && q[i] == 1'b1) begin hits++; hit_pos = i; end
        checks++;
        if (hits != 1 || hit_pos != 2) begin
            errors++;
            $display("FAIL basic_detect: got hits=%0d at bit %0d expected 1 at bit 2", hits, hit_pos);
        end
    endtask

    // Random words with random idle gaps
    task automatic test_random();
        logic [7:0] w;
        logic [4:0] obs, exp;
        int         gap;
        for (int n = 0; n < 6; n++) begin
            w   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                checks++;
                if ({m_d, m_busy, m_stb, m_last, m_ready} !== 5'b00001) begin
                    errors++;
                    $display("FAIL random_gap%0d: got %b expected %b", n, {m_d, m_busy, m_stb, m_last, m_ready}, 5'b00001);
                end
                @(negedge clk);
            end
            m_data = w; m_load = 1'b1;
            @(negedge clk);
            m_load = 1'b0; m_data = ~w;
            for (int c = 1; c <= 9; c++) begin
                obs = {m_d, m_busy, m_stb, m_last, m_ready};
                if (c <= 8) exp = {ref_bit(w, c-1, 1'b1), 1'b1, 1'b1, c == 8, c == 8};
                else        exp = 5'b00001;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random_w%0d_%h_cycle%0d: got %b expected %b", n, w, c, obs, exp);
                end
                if (c < 9) @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    // 0x05 then 0x80 loaded while last=1: 16 contiguous bits, one 101
    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [4:0]  obs, exp;
        logic        q[$];
        int          hits;
        stream = 16'h0580;
        m_data = 8'h05; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            obs = {m_d, m_busy, m_stb, m_last, m_ready};
            if (c <= 16) exp = {stream[16-c], 1'b1, 1'b1, (c == 8) || (c == 16), (c == 8) || (c == 16)};
            else         exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs, exp);
            end
            if (c <= 16) q.push_back(m_d);
            if (c <= 8 && m_last === 1'b1) begin
                m_data = 8'h80; m_load = 1'b1;
            end else begin
                m_load = 1'b0;
            end
            @(negedge clk);
        end
        hits = 0;
        for (int i = 2; i < q.size(); i++)
            if (q[i-2] == 1'b1 && q[i-1] == 1'b0 && q[i] == 1'b1) hits++;
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL b2b_detect: got %0d detections expected 1", hits);
        end
    endtask

    // Load pulsed mid-word is neither taken nor queued
    task automatic test_ignored_load();
        logic [4:0] obs, exp;
        m_data = 8'h3C; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            obs = {m_d, m_busy, m_stb, m_last, m_ready};
            if (c <= 8) exp = {ref_bit(8'h3C, c-1, 1'b1), 1'b1, 1'b1, c == 8, c == 8};
            else        exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ignored_cycle%0d: got %b expected %b", c, obs, exp);
            end
            if (c == 3) begin m_data = 8'hFF; m_load = 1'b1; end
            else        m_load = 1'b0;
            @(negedge clk);
        end
    endtask

    // DIV=3: 24 busy clocks, 8 strobes, last only on clock 24
    task automatic test_div3();
        logic [4:0] obs, exp;
        int         stbs, busys;
        stbs = 0; busys = 0;
        d3_data = 8'hA5; d3_load = 1'b1;
        @(negedge clk);
        d3_load = 1'b0; d3_data = 8'h00;
        for (int c = 1; c <= 25; c++) begin
            obs = {d3_d, d3_busy, d3_stb, d3_last, d3_ready};
            if (c <= 24) exp = {ref_bit(8'hA5, (c-1)/3, 1'b1), 1'b1, (c-1) % 3 == 0, c == 24, c == 24};
            else         exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div3_cycle%0d: got %b expected %b", c, obs, exp);
            end
            if (d3_stb === 1'b1)  stbs++;
            if (d3_busy === 1'b1) busys++;
            @(negedge clk);
        end
        checks++;
        if (stbs != 8 || busys != 24) begin
            errors++;
            $display("FAIL div3_counts: got stb=%0d busy=%0d expected stb=8 busy=24", stbs, busys);
        end
    endtask

    // LSB-first order
    task automatic test_lsb();
        logic [4:0] obs, exp;
        l_data = 8'b0000_0011; l_load = 1'b1;
        @(negedge clk);
        l_load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            obs = {l_d, l_busy, l_stb, l_last, l_ready};
            if (c <= 8) exp = {c <= 2, 1'b1, 1'b1, c == 8, c == 8};
            else        exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lsb_cycle%0d: got %b expected %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    // Asynchronous reset at bit 4 of 0xFF, then a clean word
    task automatic test_reset_mid();
        logic [4:0] obs, exp;
        m_data = 8'hFF; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            obs = {m_d, m_busy, m_stb, m_last, m_ready};
            exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid_cycle%0d: got %b expected %b", c, obs, exp);
            end
            if (c < 4) @(negedge clk);
        end
        #2 tb_rst = 1'b0;
        #1;
        checks++;
        if ({m_d, m_busy, m_stb, m_last, m_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected %b", {m_d, m_busy, m_stb, m_last, m_ready}, 5'b00001);
        end
        @(negedge clk);
        tb_rst = 1'b1;
        @(negedge clk);
        m_data = 8'hB2; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            obs = {m_d, m_busy, m_stb, m_last, m_ready};
            if (c <= 8) exp = {ref_bit(8'hB2, c-1, 1'b1), 1'b1, 1'b1, c == 8, c == 8};
            else        exp = 5'b00001;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid_after_cycle%0d: got %b expected %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_ignored_load();
        test_div3();
        test_lsb();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
